// File: rtl/frame_packetizer.sv
// Wraps each input frame as MAGIC, {seq,len}, payload, checksum, status; one cycle of IDLE before the header.
// Payload passes through combinationally, so S_AXIS_TREADY follows M_AXIS_TREADY; header/trailer words hold while stalled.
module frame_packetizer #(
  parameter int unsigned FRAME_NUM = 1024,
  parameter logic [31:0] MAGIC     = 32'h5AA5_A110,
  parameter int unsigned DW        = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] S_AXIS_TDATA,
  input  logic          S_AXIS_TVALID,
  input  logic          S_AXIS_TLAST,
  output logic          S_AXIS_TREADY,
  output logic [DW-1:0] M_AXIS_TDATA,
  output logic          M_AXIS_TVALID,
  output logic          M_AXIS_TLAST,
  input  logic          M_AXIS_TREADY,
  output logic [3:0]    M_AXIS_TSTRB,
  output logic [15:0]   seq_num,
  output logic          frame_err
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_HDR0, ST_HDR1, ST_PAYLOAD, ST_DROP, ST_CSUM, ST_STAT
  } state_t;

  localparam logic [15:0] FRAME_LEN = 16'(FRAME_NUM);
  localparam logic [16:0] FRAME_END = 17'(FRAME_NUM);

  state_t      state, state_nxt;
  logic [15:0] seq_q;
  logic [15:0] wcnt;
  logic [31:0] csum;
  logic        short_flag, long_flag;
  logic        s_beat, m_beat, last_word;
  logic [16:0] wcnt_inc;

  assign s_beat    = S_AXIS_TVALID && S_AXIS_TREADY;
  assign m_beat    = M_AXIS_TVALID && M_AXIS_TREADY;
  assign wcnt_inc  = {1'b0, wcnt} + 17'd1;
  assign last_word = (wcnt_inc == FRAME_END);

  assign M_AXIS_TSTRB = 4'hF;
  assign seq_num      = seq_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (S_AXIS_TVALID) state_nxt = ST_HDR0;
      ST_HDR0:    if (m_beat) state_nxt = ST_HDR1;
      ST_HDR1:    if (m_beat) state_nxt = ST_PAYLOAD;
      ST_PAYLOAD: if (s_beat) begin
                    if (S_AXIS_TLAST)   state_nxt = ST_CSUM;
                    else if (last_word) state_nxt = ST_DROP;
                  end
      ST_DROP:    if (s_beat && S_AXIS_TLAST) state_nxt = ST_CSUM;
      ST_CSUM:    if (m_beat) state_nxt = ST_STAT;
      ST_STAT:    if (m_beat) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    S_AXIS_TREADY = 1'b0;
    M_AXIS_TVALID = 1'b0;
    M_AXIS_TDATA  = '0;
    M_AXIS_TLAST  = 1'b0;
    frame_err     = 1'b0;
    case (state)
      ST_HDR0: begin
        M_AXIS_TVALID = 1'b1;
        M_AXIS_TDATA  = MAGIC;
      end
      ST_HDR1: begin
        M_AXIS_TVALID = 1'b1;
        M_AXIS_TDATA  = {seq_q, FRAME_LEN};
      end
      ST_PAYLOAD: begin
        M_AXIS_TVALID = S_AXIS_TVALID;
        M_AXIS_TDATA  = S_AXIS_TDATA;
        S_AXIS_TREADY = M_AXIS_TREADY;
      end
      ST_DROP: S_AXIS_TREADY = 1'b1;
      ST_CSUM: begin
        M_AXIS_TVALID = 1'b1;
        M_AXIS_TDATA  = csum;
      end
      ST_STAT: begin
        M_AXIS_TVALID = 1'b1;
        M_AXIS_TLAST  = 1'b1;
        M_AXIS_TDATA  = {4'hE, 10'b0, short_flag, long_flag, wcnt};
        frame_err     = M_AXIS_TREADY && (short_flag || long_flag);
      end
      default: ;
    endcase
  end

  // Counters only move on accepted payload beats; dropped overflow words never reach them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_q      <= '0;
      wcnt       <= '0;
      csum       <= '0;
      short_flag <= 1'b0;
      long_flag  <= 1'b0;
    end else if (state == ST_PAYLOAD && s_beat) begin
      wcnt <= wcnt_inc[15:0];
      csum <= csum + S_AXIS_TDATA;
      if (S_AXIS_TLAST && !last_word)      short_flag <= 1'b1;
      else if (!S_AXIS_TLAST && last_word) long_flag  <= 1'b1;
    end else if (state == ST_STAT && m_beat) begin
      seq_q      <= seq_q + 16'd1;
      wcnt       <= '0;
      csum       <= '0;
      short_flag <= 1'b0;
      long_flag  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_frame_packetizer.sv
// Scoreboard bench for frame_packetizer: stimulus queues expected beats, a negedge monitor checks them.
module tb_frame_packetizer;

  localparam int unsigned FN    = 1024;
  localparam logic [31:0] MAGIC = 32'h5AA5_A110;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] S_AXIS_TDATA = '0;
  logic        S_AXIS_TVALID = 1'b0;
  logic        S_AXIS_TLAST = 1'b0;
  logic        S_AXIS_TREADY;
  logic [31:0] M_AXIS_TDATA;
  logic        M_AXIS_TVALID;
  logic        M_AXIS_TLAST;
  logic        M_AXIS_TREADY = 1'b1;
  logic [3:0]  M_AXIS_TSTRB;
  logic [15:0] seq_num;
  logic        frame_err;

  typedef struct packed {
    logic [31:0] dat;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          err_pulses = 0;
  int          err_exp = 0;
  logic [15:0] seq_exp = '0;
  logic        rnd_mode = 1'b0;
  logic        gap_mode = 1'b0;

  always #5 clk = ~clk;

  frame_packetizer #(.FRAME_NUM(FN), .MAGIC(MAGIC), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TVALID(S_AXIS_TVALID),
    .S_AXIS_TLAST(S_AXIS_TLAST), .S_AXIS_TREADY(S_AXIS_TREADY),
    .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TVALID(M_AXIS_TVALID),
    .M_AXIS_TLAST(M_AXIS_TLAST), .M_AXIS_TREADY(M_AXIS_TREADY),
    .M_AXIS_TSTRB(M_AXIS_TSTRB), .seq_num(seq_num), .frame_err(frame_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] d, input logic l);
    exp_t e;
    e.dat  = d;
    e.last = l;
    return e;
  endfunction

  // Every presented word (stalled or not) must match the queue head, so stall stability is checked too.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) err_pulses++;
      if (M_AXIS_TVALID) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", M_AXIS_TDATA, 32'hDEAD_BEEF ^ M_AXIS_TDATA ^ 32'h1);
        end else begin
          check("out_data", M_AXIS_TDATA, exp_q[0].dat);
          check("out_last", {31'b0, M_AXIS_TLAST}, {31'b0, exp_q[0].last});
          if (M_AXIS_TREADY) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1 M_AXIS_TREADY = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic reset_checks();
    check("rst_m_tvalid", {31'b0, M_AXIS_TVALID}, 32'd0);
    check("rst_s_tready", {31'b0, S_AXIS_TREADY}, 32'd0);
    check("rst_m_tlast",  {31'b0, M_AXIS_TLAST},  32'd0);
    check("rst_m_tdata",  M_AXIS_TDATA,           32'd0);
    check("rst_frame_err", {31'b0, frame_err},    32'd0);
    check("rst_seq_num",  {16'b0, seq_num},       32'd0);
    check("rst_tstrb",    {28'b0, M_AXIS_TSTRB},  32'hF);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TLAST = 1'b0;
    #1 reset_checks();
    exp_q.delete();
    seq_exp = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input logic last, input logic drop_chk);
    int   t;
    logic acc;
    if (gap_mode && $urandom_range(0, 3) == 0) begin
      S_AXIS_TVALID = 1'b0;
      repeat ($urandom_range(1, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    S_AXIS_TDATA  = d;
    S_AXIS_TLAST  = last;
    S_AXIS_TVALID = 1'b1;
    t = 0;
    acc = 1'b0;
    while (!acc && t < 2000) begin
      @(negedge clk);
      acc = S_AXIS_TREADY;
      t++;
      if (acc && drop_chk) check("drop_m_tvalid", {31'b0, M_AXIS_TVALID}, 32'd0);
      @(posedge clk);
      #1;
    end
    if (!acc) check("word_accept_timeout", 32'd0, 32'd1);
  endtask

  // kind: 0 ramp i, 1 (i+1)*0x11111111, 2 random. Hand-computed csum/status unless use_model.
  task automatic send_frame(input int n, input int kind, input logic use_model,
                            input logic [31:0] hc_csum, input logic [31:0] hc_stat,
                            input int abort_at);
    logic [31:0] w[$];
    logic [31:0] d, cs, st;
    int          keep, t;
    logic        sh, lg;
    keep = (n < int'(FN)) ? n : int'(FN);
    cs = '0;
    for (int i = 0; i < n; i++) begin
      case (kind)
        0:       d = 32'(i);
        1:       d = 32'(i + 1) * 32'h1111_1111;
        default: d = $urandom();
      endcase
      w.push_back(d);
      if (i < keep) cs = cs + d;
    end
    sh = (n < int'(FN));
    lg = (n > int'(FN));
    st = {4'hE, 10'b0, sh, lg, 16'(keep)};
    if (!use_model) begin
      cs = hc_csum;
      st = hc_stat;
    end
    exp_q.push_back(mk(MAGIC, 1'b0));
    exp_q.push_back(mk({seq_exp, 16'(FN)}, 1'b0));
    for (int i = 0; i < keep; i++) exp_q.push_back(mk(w[i], 1'b0));
    exp_q.push_back(mk(cs, 1'b0));
    exp_q.push_back(mk(st, 1'b1));
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) begin
        S_AXIS_TDATA  = w[i];
        S_AXIS_TLAST  = 1'b0;
        S_AXIS_TVALID = 1'b1;
        #2;
        return;
      end
      send_word(w[i], i == n - 1, i >= int'(FN));
    end
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TLAST  = 1'b0;
    t = 0;
    while (exp_q.size() > 0 && t < 5000) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (exp_q.size() > 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    seq_exp = seq_exp + 16'd1;
    if (sh || lg) err_exp++;
    check("seq_after_frame", {16'b0, seq_num}, {16'b0, seq_exp});
    check("frame_err_count", 32'(err_pulses), 32'(err_exp));
  endtask

  initial begin
    #2 do_reset();

    // Nominal 1024-word ramp: sum 0..1023 = 0x7FE00.
    send_frame(1024, 0, 1'b0, 32'h0007_FE00, 32'hE000_0400, -1);
    check("seq_one", {16'b0, seq_num}, 32'd1);

    // Reset while payload word 500 is on the bus.
    send_frame(1024, 0, 1'b0, 32'h0007_FE00, 32'hE000_0400, 500);
    check("abort_m_tvalid_pre", {31'b0, M_AXIS_TVALID}, 32'd1);
    do_reset();

    // Random backpressure and source gaps over three frames (seq 0,1,2).
    rnd_mode = 1'b1;
    gap_mode = 1'b1;
    for (int f = 0; f < 3; f++) send_frame(1024, 2, 1'b1, '0, '0, -1);
    rnd_mode = 1'b0;
    gap_mode = 1'b0;

    // Short frame: 10 words, sum 55*0x11111111 mod 2^32.
    send_frame(10, 1, 1'b0, 32'hAAAA_AAA7, 32'hE002_000A, -1);

    // Long frame: 1030 words, last 6 dropped.
    send_frame(1030, 0, 1'b0, 32'h0007_FE00, 32'hE001_0400, -1);

    // Sequence wrap: preload FFFF, next header carries FFFF and the counter returns to 0.
    force dut.seq_q = 16'hFFFF;
    #1 release dut.seq_q;
    seq_exp = 16'hFFFF;
    send_frame(1024, 0, 1'b0, 32'h0007_FE00, 32'hE000_0400, -1);
    check("seq_wrap", {16'b0, seq_num}, 32'h0000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/frame_packetizer.md
# frame_packetizer

Wraps each AXI-Stream frame from the LVDS receive stage (32-bit words, one frame per TLAST) in a fixed header and trailer before it goes to the DMA/UDP path. The host can then detect lost frames, truncated frames and data corruption.

- Header: magic word, sequence number, expected length.
- Trailer: 32-bit payload checksum and a status word.
- Position: between the receiver's M_AXIS output and the DMA S2MM stream input, in the M_AXIS_ACLK domain.

## Interface
Parameters:
- FRAME_NUM, 1024: expected payload words per frame, 1..65535.
- MAGIC, 32'h5AA5_A110: header word 0.
- DW, 32: TDATA width. Only 32 is supported.

Ports:
- clk  in  1  stream clock. The block has one clock; clk is it.
- rst  in  1  asynchronous, active-high reset.
- S_AXIS_TDATA  in  32  payload from the receiver.
- S_AXIS_TVALID  in  1  input valid.
- S_AXIS_TLAST  in  1  last payload word of the frame.
- S_AXIS_TREADY  out  1  input accept.
- M_AXIS_TDATA  out  32  packetized output.
- M_AXIS_TVALID  out  1  output valid.
- M_AXIS_TLAST  out  1  high on the status word only.
- M_AXIS_TREADY  in  1  downstream accept.
- M_AXIS_TSTRB  out  4  constant 4'hF.
- seq_num  out  16  sequence number of the next frame.
- frame_err  out  1  one-cycle pulse when a status word with a nonzero flag is accepted.

## Operation
Beat rules:
- A beat transfers when VALID and READY are both high.
- Output order per frame: HDR0 = MAGIC; HDR1 = {seq_num, FRAME_NUM[15:0]}; payload words; CSUM; STAT.

States:
- IDLE
  - S_TREADY=0, M_TVALID=0.
  - Goes to HDR0 when S_TVALID=1. The first payload word is not consumed here.
- HDR0
  - M_TVALID=1, M_TDATA=MAGIC.
  - Goes to HDR1 on an output beat.
- HDR1
  - M_TVALID=1, M_TDATA={seq_num, FRAME_NUM}.
  - Goes to PAYLOAD on an output beat.
- PAYLOAD (combinational pass-through)
  - M_TDATA=S_TDATA, M_TVALID=S_TVALID, S_TREADY=M_TREADY, M_TLAST=0.
  - On each beat: wcnt += 1 and csum += S_TDATA (mod 2^32).
  - If S_TLAST on the beat and wcnt+1 < FRAME_NUM: set short, go to CSUM.
  - If S_TLAST on the beat and wcnt+1 == FRAME_NUM: go to CSUM with no flag.
  - If wcnt+1 == FRAME_NUM without S_TLAST: set long, go to DROP.
- DROP
  - S_TREADY=1, M_TVALID=0.
  - Input beats are discarded and do not touch csum or wcnt.
  - Goes to CSUM on an input beat with S_TLAST.
- CSUM
  - M_TVALID=1, M_TDATA=csum.
  - Goes to STAT on an output beat.
- STAT
  - M_TVALID=1, M_TLAST=1.
  - M_TDATA = {4'hE, 10'b0, short, long, wcnt[15:0]}.
  - On an output beat: seq_num += 1 (wraps FFFF→0000); clear csum, wcnt, short, long; pulse frame_err if short|long; go to IDLE.

Other rules:
- S_TREADY=0 in every state other than PAYLOAD and DROP.
- wcnt is 16 bits. It never exceeds FRAME_NUM.

## Timing
Reset (rst high):
- Asserts immediately (async) and releases on a clk edge.
- State=IDLE; seq_num=0; csum=0; wcnt=0; flags=0.
- All outputs 0 except M_TSTRB=4'hF: S_TREADY=0, M_TVALID=0, M_TLAST=0, M_TDATA=0, frame_err=0.

Latency and throughput:
- One cycle from S_TVALID rising (in IDLE) to HDR0 valid.
- Payload has zero latency, since it is combinational.
- Framing overhead with M_TREADY held high: 5 cycles per frame (IDLE detect, HDR0, HDR1, CSUM, STAT).

Handshake rules:
- Header and trailer words hold M_TDATA stable while M_TVALID=1 && M_TREADY=0.
- M_TVALID never deasserts before its beat, except in PAYLOAD, where it follows S_TVALID.

Reset mid-frame:
- The output aborts without a TLAST.
- Downstream must tolerate this; the DMA is reset together with this block.

Boundaries:
- FRAME_NUM=1: a single word with TLAST is a good frame. A single word without TLAST sets long.
- TLAST and the FRAME_NUM-th word on the same beat: no flag.

## Test plan
- Reset, then a 1024-word ramp 0..1023 with TLAST on the last word, M_TREADY=1. Required output: MAGIC; 32'h0000_0400; ramp; CSUM=32'h0007_FE00; STAT=32'hE000_0400 with TLAST; seq_num=1; frame_err stays 0.
- Random M_TREADY at 50% with random S_TVALID gaps over 3 frames. Required: header and trailer words stay stable while stalled; payload is unchanged; HDR1 reads 0000_0400, 0001_0400, 0002_0400.
- TLAST on word 10 (0-based 9). Required: CSUM equals the sum of those 10 words; STAT=32'hE002_000A; frame_err pulses once.
- 1030 words with TLAST on the last. Required: the first 1024 pass through; 6 words are dropped with S_TREADY=1 and M_TVALID=0; STAT=32'hE001_0400; the next frame's header is clean.
- Preload seq_num to FFFF (run 65535 frames, or force). Required: the next HDR1=32'hFFFF_0400, after which seq_num=0000.
- Assert rst during PAYLOAD word 500. Required: outputs 0 immediately; the next frame starts with MAGIC and seq_num=0.
